// File: rtl/miner_round_sched.sv
// Round/pass sequencer for one double-SHA-256 mining core: walks each nonce through
// two compression passes and a target compare, iterating over a host-given nonce range.
module miner_round_sched #(
    parameter int ROUNDS  = 64,
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic               cmp_valid,
    input  logic               cmp_hit,
    output logic               ld_state,
    output logic               rnd_en,
    output logic [5:0]         rnd_idx,
    output logic               pass,
    output logic               w_msg_sel,
    output logic               add_en,
    output logic               cmp_req,
    output logic [NONCE_W-1:0] nonce,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce
);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, ADD, CHECK, DONE} state_t;

    localparam logic [5:0] LAST_RND = 6'(ROUNDS - 1);

    state_t             state;
    logic [6:0]         cnt;
    logic [NONCE_W-1:0] nonce_last;

    assign pass    = cnt[6];
    assign rnd_idx = cnt[5:0];

    // Every output is a registered decode of the state being entered, so each
    // transition below also sets the strobes for the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            nonce_last  <= '0;
            nonce       <= '0;
            found       <= 1'b0;
            found_nonce <= '0;
            ld_state    <= 1'b0;
            rnd_en      <= 1'b0;
            w_msg_sel   <= 1'b0;
            add_en      <= 1'b0;
            cmp_req     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // NOTE: strobe defaults first; a later non-blocking assignment in the
            // same pass overrides them, so each branch names only what it raises.
            ld_state  <= 1'b0;
            rnd_en    <= 1'b0;
            w_msg_sel <= 1'b0;
            add_en    <= 1'b0;
            cmp_req   <= 1'b0;
            done      <= 1'b0;

            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            nonce_last <= nonce_end;
                            nonce      <= nonce_start;
                            found      <= 1'b0;
                            cnt        <= 7'd0;
                            ld_state   <= 1'b1;
                            busy       <= 1'b1;
                            state      <= LOAD;
                        end
                    end
                    LOAD: begin
                        rnd_en    <= 1'b1;
                        w_msg_sel <= 1'b1;
                        state     <= ROUND;
                    end
                    ROUND: begin
                        // The last round holds cnt so pass still names the finishing pass in ADD.
                        if (rnd_idx == LAST_RND) begin
                            add_en <= 1'b1;
                            state  <= ADD;
                        end else begin
                            cnt       <= cnt + 7'd1;
                            rnd_en    <= 1'b1;
                            w_msg_sel <= (rnd_idx < 6'd15);
                        end
                    end
                    ADD: begin
                        if (!pass) begin
                            cnt      <= 7'd64;
                            ld_state <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            cmp_req <= 1'b1;
                            state   <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (!cmp_valid) begin
                            cmp_req <= 1'b1;
                        end else if (cmp_hit) begin
                            found       <= 1'b1;
                            found_nonce <= nonce;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else if (nonce == nonce_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            // Plain increment: a range with end below start wraps through zero.
                            nonce    <= nonce + NONCE_W'(1);
                            cnt      <= 7'd0;
                            ld_state <= 1'b1;
                            state    <= LOAD;
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_miner_round_sched.sv
// Self-checking bench for miner_round_sched: an expected per-cycle trace is built from the
// search rules (phases per nonce, range walk, compare stalls) and compared every cycle.
module tb_miner_round_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] nonce_start = '0;
    logic [31:0] nonce_end = '0;
    logic        cmp_valid = 1'b0;
    logic        cmp_hit = 1'b0;
    logic        ld_state, rnd_en, pass, w_msg_sel, add_en, cmp_req, busy, done, found;
    logic [5:0]  rnd_idx;
    logic [31:0] nonce, found_nonce;

    miner_round_sched #(.ROUNDS(64), .NONCE_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .nonce_start(nonce_start), .nonce_end(nonce_end),
        .cmp_valid(cmp_valid), .cmp_hit(cmp_hit),
        .ld_state(ld_state), .rnd_en(rnd_en), .rnd_idx(rnd_idx), .pass(pass),
        .w_msg_sel(w_msg_sel), .add_en(add_en), .cmp_req(cmp_req), .nonce(nonce),
        .busy(busy), .done(done), .found(found), .found_nonce(found_nonce)
    );

    always #5 clk = ~clk;

    // One expected cycle: outputs plus the compare inputs to drive in that cycle.
    typedef struct {
        bit        ld, rnd, add, req, dn, busy, wsel, pas, fnd, cv, ch;
        bit [5:0]  idx;
        bit [31:0] nonce, fn;
    } exp_t;

    exp_t        plan[$];
    exp_t        e;
    bit [31:0]   m_nonce = '0, m_fn = '0;
    bit          m_found = 1'b0;
    int          errors = 0, checks = 0;
    int          cur_cycle = 0;
    int          done_cnt, done_cyc, add_cnt, rnd_cnt, req_cnt, flip_cyc;
    bit          saw12;
    bit [31:0]   seen[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cur_cycle, act, exp_v);
        end
    endtask

    function automatic exp_t idle_exp();
        exp_t x = '{default: 0};
        x.nonce = m_nonce;
        x.fnd   = m_found;
        x.fn    = m_fn;
        return x;
    endfunction

    function automatic exp_t busy_exp(input bit [31:0] n);
        exp_t x = '{default: 0};
        x.busy  = 1'b1;
        x.nonce = n;
        x.fn    = m_fn;
        x.cv    = 1'($urandom);
        x.ch    = 1'($urandom);
        return x;
    endfunction

    // Expected trace of a whole search, one entry per cycle after the start edge.
    task automatic build(input bit [31:0] ns, input bit [31:0] ne, input bit hit_en,
                         input bit [31:0] hn, input int st_lo, input int st_hi);
        bit [31:0] n = ns;
        exp_t      x;
        int        s;
        plan.delete();
        forever begin
            for (int p = 0; p < 2; p++) begin
                x = busy_exp(n); x.ld = 1'b1; x.pas = p[0]; plan.push_back(x);
                for (int r = 0; r < 64; r++) begin
                    x = busy_exp(n); x.rnd = 1'b1; x.pas = p[0]; x.idx = 6'(r);
                    x.wsel = (r < 16);
                    plan.push_back(x);
                end
                x = busy_exp(n); x.add = 1'b1; x.pas = p[0]; plan.push_back(x);
            end
            s = int'($urandom_range(st_hi, st_lo));
            repeat (s) begin
                x = busy_exp(n); x.req = 1'b1; x.cv = 1'b0; plan.push_back(x);
            end
            x = busy_exp(n); x.req = 1'b1; x.cv = 1'b1; x.ch = hit_en && (n == hn);
            plan.push_back(x);
            if (x.ch || n == ne) begin
                x = busy_exp(n); x.dn = 1'b1; x.fnd = hit_en && (n == hn);
                x.fn = x.fnd ? n : m_fn;
                plan.push_back(x);
                break;
            end
            n = n + 32'd1;
        end
    endtask

    task automatic compare();
        check("ld_state", 64'(ld_state), 64'(e.ld));
        check("rnd_en", 64'(rnd_en), 64'(e.rnd));
        check("add_en", 64'(add_en), 64'(e.add));
        check("cmp_req", 64'(cmp_req), 64'(e.req));
        check("done", 64'(done), 64'(e.dn));
        check("busy", 64'(busy), 64'(e.busy));
        check("w_msg_sel", 64'(w_msg_sel), 64'(e.wsel));
        check("nonce", 64'(nonce), 64'(e.nonce));
        check("found", 64'(found), 64'(e.fnd));
        if (e.fnd) check("found_nonce", 64'(found_nonce), 64'(e.fn));
        if (e.rnd) check("rnd_idx", 64'(rnd_idx), 64'(e.idx));
        if (e.ld || e.rnd || e.add) check("pass", 64'(pass), 64'(e.pas));
        if (done) begin done_cnt++; done_cyc = cur_cycle; end
        if (add_en) add_cnt++;
        if (rnd_en) rnd_cnt++;
        if (cmp_req) req_cnt++;
        if (busy && pass && flip_cyc == 0) flip_cyc = cur_cycle;
        if (busy && nonce == 32'd12) saw12 = 1'b1;
        if (ld_state && !pass) seen.push_back(nonce);
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".ld_state"}, 64'(ld_state), 64'd0);
        check({tag, ".rnd_en"}, 64'(rnd_en), 64'd0);
        check({tag, ".rnd_idx"}, 64'(rnd_idx), 64'd0);
        check({tag, ".pass"}, 64'(pass), 64'd0);
        check({tag, ".w_msg_sel"}, 64'(w_msg_sel), 64'd0);
        check({tag, ".add_en"}, 64'(add_en), 64'd0);
        check({tag, ".cmp_req"}, 64'(cmp_req), 64'd0);
        check({tag, ".nonce"}, 64'(nonce), 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd0);
        check({tag, ".found"}, 64'(found), 64'd0);
        check({tag, ".found_nonce"}, 64'(found_nonce), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            cmp_valid = 1'($urandom);
            cmp_hit   = 1'($urandom);
            abort     = 1'($urandom);
            start     = 1'b0;
            e         = idle_exp();
            cur_cycle++;
            tick();
        end
        abort = 1'b0;
    endtask

    // One search; abort_at / rst_at are trace indices (cycle = index + 1), -1 for none.
    task automatic run(input bit [31:0] ns, input bit [31:0] ne, input bit hit_en,
                       input bit [31:0] hn, input int st_lo, input int st_hi,
                       input int abort_at, input int rst_at);
        exp_t last;
        build(ns, ne, hit_en, hn, st_lo, st_hi);
        done_cnt = 0; done_cyc = 0; add_cnt = 0; rnd_cnt = 0; req_cnt = 0;
        flip_cyc = 0; saw12 = 1'b0; seen.delete();
        start = 1'b1; abort = 1'b0; nonce_start = ns; nonce_end = ne;
        e = idle_exp(); cur_cycle = 0;
        tick();
        for (int k = 0; k < plan.size(); k++) begin
            e           = plan[k];
            cur_cycle   = k + 1;
            cmp_valid   = e.cv;
            cmp_hit     = e.ch;
            abort       = (k == abort_at);
            start       = abort ? 1'b1 : 1'($urandom);
            nonce_start = $urandom;
            nonce_end   = $urandom;
            if (k == rst_at) begin
                @(negedge clk);
                compare();
                #2;
                rst_n = 1'b0;
                #1;
                check_zero("mid_reset");
                start = 1'b0; abort = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                m_nonce = '0; m_found = 1'b0; m_fn = '0;
                e = idle_exp();
                return;
            end
            tick();
            if (k == abort_at) begin
                m_nonce = e.nonce; m_found = e.fnd;
                if (e.fnd) m_fn = e.fn;
                start = 1'b0; abort = 1'b0;
                e = idle_exp();
                return;
            end
        end
        last = plan[plan.size() - 1];
        m_nonce = last.nonce; m_found = last.fnd;
        if (last.fnd) m_fn = last.fn;
        start = 1'b0;
        e = idle_exp();
    endtask

    initial begin
        bit [31:0] ns, hn;
        int        len, ab;
        #12;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Single nonce, zero-wait compare, no hit.
        run(32'd5, 32'd5, 1'b0, 32'd0, 0, 0, -1, -1);
        idle(2);
        check("t1.model_len", 64'(plan.size()), 64'd134);
        check("t1.done_cycle", 64'(done_cyc), 64'd134);
        check("t1.done_pulses", 64'(done_cnt), 64'd1);
        check("t1.add_pulses", 64'(add_cnt), 64'd2);
        check("t1.round_cycles", 64'(rnd_cnt), 64'd128);
        check("t1.pass_flip", 64'(flip_cyc), 64'd67);
        check("t1.found", 64'(found), 64'd0);

        // Range 10..12 with a hit on 11.
        run(32'd10, 32'd12, 1'b1, 32'd11, 0, 0, -1, -1);
        idle(2);
        check("t2.model_len", 64'(plan.size()), 64'd267);
        check("t2.done_cycle", 64'(done_cyc), 64'd267);
        check("t2.found", 64'(found), 64'd1);
        check("t2.found_nonce", 64'(found_nonce), 64'd11);
        check("t2.nonce12_seen", 64'(saw12), 64'd0);

        // Wrapping range.
        run(32'hFFFF_FFFF, 32'h0, 1'b0, 32'd0, 0, 0, -1, -1);
        idle(2);
        check("t3.done_cycle", 64'(done_cyc), 64'd267);
        check("t3.nonces_tested", 64'(seen.size()), 64'd2);
        if (seen.size() == 2) begin
            check("t3.first_nonce", 64'(seen[0]), 64'hFFFF_FFFF);
            check("t3.second_nonce", 64'(seen[1]), 64'd0);
        end
        check("t3.found", 64'(found), 64'd0);

        // Compare stall of five cycles.
        run(32'd7, 32'd7, 1'b0, 32'd0, 5, 5, -1, -1);
        idle(2);
        check("t4.req_cycles", 64'(req_cnt), 64'd6);
        check("t4.done_cycle", 64'(done_cyc), 64'd139);

        // Abort at cycle 40, then a clean restart.
        run(32'd20, 32'd30, 1'b0, 32'd0, 0, 2, 39, -1);
        idle(3);
        check("t5.done_after_abort", 64'(done_cnt), 64'd0);
        run(32'd5, 32'd5, 1'b0, 32'd0, 0, 0, -1, -1);
        idle(2);
        check("t5.restart_done_cycle", 64'(done_cyc), 64'd134);

        // Reset pulsed at cycle 100.
        run(32'd1, 32'd3, 1'b0, 32'd0, 0, 0, -1, 99);
        idle(3);
        check("t6.done_after_reset", 64'(done_cnt), 64'd0);

        // Randomised searches: short ranges, some near the wrap point, random hits, stalls, aborts.
        for (int i = 0; i < 12; i++) begin
            len = int'($urandom_range(3, 1));
            ns  = (i % 4 == 0) ? 32'hFFFF_FFFF - $urandom_range(2, 0) : $urandom;
            hn  = ns + $urandom_range(len, 0);
            ab  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(400, 0)) : -1;
            run(ns, ns + 32'(len - 1), 1'($urandom), hn, 0, 3, ab, -1);
            idle(int'($urandom_range(3, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/miner_round_sched.md
# miner_round_sched

Sequencer for one double-SHA-256 mining core. It drives the round datapath through two 64-round compression passes per nonce, then requests a target compare. It iterates nonces over a host-given range until it gets a hit, exhausts the range, or is aborted. It sits between the host control registers and the hash round/compare datapath, and it owns the 7-bit round counter, whose bit 6 is the pass index.

## Interface
- ROUNDS, 64, rounds per compression pass; must be a power of two ≤ 64.
- NONCE_W, 32, nonce width.

Clock and reset: one clock; reset is asynchronous and active-low.

- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a search; sampled only in IDLE
- abort  in  1  stop the search; highest priority after reset
- nonce_start  in  NONCE_W  first nonce; captured on accepted start
- nonce_end  in  NONCE_W  last nonce, inclusive; captured on accepted start
- cmp_valid  in  1  compare result valid; may be high in the same cycle as cmp_req
- cmp_hit  in  1  hash meets target; qualified by cmp_valid
- ld_state  out  1  load working regs: midstate in pass 0, IV plus digest-as-message in pass 1
- rnd_en  out  1  advance one compression round
- rnd_idx  out  6  current round, 0..ROUNDS-1
- pass  out  1  0 = header pass, 1 = hash-of-hash pass
- w_msg_sel  out  1  1 when rnd_idx < 16 (message word), else schedule expansion
- add_en  out  1  one-cycle digest feed-forward add
- cmp_req  out  1  held high until cmp_valid
- nonce  out  NONCE_W  nonce under test
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at search end; not asserted on abort
- found  out  1  result flag, valid from done until the next accepted start
- found_nonce  out  NONCE_W  winning nonce, valid when found=1

## Operation
- Internal 7-bit counter cnt: pass = cnt[6], rnd_idx = cnt[5:0].
  - Cleared to 0 in LOAD for pass 0.
  - Set to 64 in LOAD for pass 1.
  - Incremented when rnd_en=1.
- States: IDLE, LOAD, ROUND, ADD, CHECK, DONE.
- IDLE: start=1 → capture nonce_start and nonce_end, set nonce = nonce_start, clear found, go to LOAD.
- LOAD (1 cycle): ld_state=1; → ROUND.
- ROUND: rnd_en=1 every cycle; when rnd_idx = ROUNDS-1 → ADD.
- ADD (1 cycle): add_en=1.
  - pass=0 → LOAD, which sets cnt=64.
  - pass=1 → CHECK.
- CHECK: cmp_req=1 until cmp_valid=1.
  - cmp_hit=1 → DONE with found=1 and found_nonce=nonce.
  - Else, nonce = captured end → DONE with found=0.
  - Else nonce ← nonce+1 modulo 2^NONCE_W, then → LOAD with pass 0.
- DONE (1 cycle): done=1; → IDLE.
- Range rules:
  - Equality test only, so nonce_end < nonce_start wraps through 2^NONCE_W-1 to 0.
  - nonce_start = nonce_end tests exactly one nonce.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; all strobes are low from that cycle on.
  - found is unchanged; done is not pulsed.
  - start in the same cycle as abort is ignored.
- start while busy is ignored.
- Only one of ld_state, rnd_en, add_en, cmp_req is high in any cycle.

## Timing
- Reset values: state IDLE; every output 0, including nonce, found_nonce and cnt.
- Reset asserted mid-search clears everything immediately; no done is pulsed.
- Outputs are registered state decodes, valid in the cycle the state is entered.
- Per-nonce cycle budget: LOAD 1, ROUND 64, ADD 1, LOAD 1, ROUND 64, ADD 1, CHECK ≥1; 133 cycles minimum.
- Timeline with start accepted at edge 0 and zero-wait compare:
  - LOAD in cycle 1; rounds in cycles 2–65; ADD at 66.
  - LOAD at 67; rounds in cycles 68–131; ADD at 132.
  - CHECK at 133; done at 134.
- Each cycle of cmp_valid=0 in CHECK adds one cycle.
- Throughput: N nonces with no hit take 133·N + 1 cycles from start to done.

## Test plan
- Reset, then start with nonce_start = nonce_end = 5, cmp_valid tied 1, cmp_hit 0 → done at cycle 134, found=0; rnd_idx goes 0..63 twice; pass flips at cycle 67; exactly two add_en pulses.
- Range 10..12, cmp_hit=1 only when nonce=11 → done at cycle 267, found=1, found_nonce=11; nonce 12 is never driven.
- Wrap: range 0xFFFFFFFF..0x00000000, no hit → nonces tested are 0xFFFFFFFF then 0; done at cycle 267, found=0.
- Compare stall: cmp_valid low for 5 cycles in CHECK → cmp_req held 6 cycles; done at cycle 139.
- abort at cycle 40 mid-ROUND → IDLE at 41; busy=0, rnd_en=0, no done pulse; a new start then runs normally from cycle 0 timing.
- rst_n pulsed low at cycle 100 → all outputs 0 asynchronously; start held high while busy → ignored, with no restart at DONE.
